// File: rtl/hfifo_delay_sel.sv
// hfifo_delay_sel: NUM_LANE-tap horizontal delay FIFO, lane k delayed by k*STEP enabled cycles.
// Optional macro HFIFO_ZERO_INVALID_EN forces fifo_out to 0 whenever out_valid is low.
module hfifo_delay_sel #(
    parameter int unsigned P_WIDTH  = 64,
    parameter int unsigned NUM_LANE = 4,
    parameter int unsigned STEP     = 4,
    localparam int unsigned MODE_W  = (NUM_LANE > 2) ? $clog2(NUM_LANE) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LANE*P_WIDTH-1:0] data_in,
    input  logic [NUM_LANE-1:0]         in_valid,
    input  logic                        en,
    input  logic [MODE_W-1:0]           mode,
    output logic [P_WIDTH-1:0]          fifo_out,
    output logic                        out_valid,
    output logic                        primed
);

    localparam int unsigned PRIME_MAX = (NUM_LANE - 1) * STEP;
    localparam int unsigned CNT_W     = $clog2(PRIME_MAX + 1);

    logic [NUM_LANE-1:0][P_WIDTH-1:0] lane_data;
    logic [NUM_LANE-1:0]              lane_valid;
    logic [CNT_W-1:0]                 prime_cnt;
    logic [31:0]                      mode_idx;
    logic                             mode_ok;
    logic [P_WIDTH-1:0]               sel_data;
    logic                             sel_valid;

    // Lane 0 has no storage and follows its input even while stalled.
    assign lane_data[0]  = data_in[P_WIDTH-1:0];
    assign lane_valid[0] = in_valid[0];

    for (genvar k = 1; k < NUM_LANE; k++) begin : g_lane
        localparam int unsigned DEPTH = k * STEP;

        logic [P_WIDTH-1:0] data_q  [DEPTH];
        logic               valid_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i]  <= '0;
                    valid_q[i] <= 1'b0;
                end
            end else if (en) begin
                data_q[0]  <= data_in[k*P_WIDTH +: P_WIDTH];
                valid_q[0] <= in_valid[k];
                for (int i = 1; i < DEPTH; i++) begin
                    data_q[i]  <= data_q[i-1];
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        assign lane_data[k]  = data_q[DEPTH-1];
        assign lane_valid[k] = valid_q[DEPTH-1];
    end

    // Saturates at the deepest lane's depth so primed never drops back after a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (en && (prime_cnt != CNT_W'(PRIME_MAX))) begin
            prime_cnt <= prime_cnt + CNT_W'(1);
        end
    end

    assign mode_idx = 32'(mode);
    assign mode_ok  = (mode_idx < NUM_LANE);

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_LANE; k++) begin
            if (mode_idx == 32'(k)) begin
                sel_data  = lane_data[k];
                sel_valid = lane_valid[k];
            end
        end
    end

    assign out_valid = sel_valid;
    assign primed    = mode_ok && (32'(prime_cnt) >= (mode_idx * STEP));

`ifdef HFIFO_ZERO_INVALID_EN
    assign fifo_out = sel_valid ? sel_data : '0;
`else
    assign fifo_out = sel_data;
`endif

endmodule

// File: tb/tb_hfifo_delay_sel.sv
// Self-checking bench for hfifo_delay_sel (P_WIDTH=64, NUM_LANE=4, STEP=4) using a
// due-edge scoreboard of expected output words.
module tb_hfifo_delay_sel;

    logic         clk;
    logic         rst;
    logic [255:0] data_in;
    logic [3:0]   in_valid;
    logic         en;
    logic [1:0]   mode;
    logic [63:0]  fifo_out;
    logic         out_valid;
    logic         primed;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;  // enabled edges since the last reset edge

    hfifo_delay_sel #(
        .P_WIDTH  (64),
        .NUM_LANE (4),
        .STEP     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .en        (en),
        .mode      (mode),
        .fifo_out  (fifo_out),
        .out_valid (out_valid),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        logic r;
        logic e;
        r = rst;
        e = en;
        @(posedge clk);
        #1;
        if (r) edges = 0;
        else if (e) edges++;
    endtask

    task automatic set_lane(input int k, input logic [63:0] v);
        data_in[k*64 +: 64] = v;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        in_valid = '0;
        data_in  = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        en       = 1'b1;
        in_valid = 4'hF;
        data_in  = {4{64'hDEAD_BEEF_0123_4567}};
        mode     = 2'd3;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0 || fifo_out !== 64'h0) begin
            bad++;
            $display("FAIL reset_lane3: got v=%b d=%h want v=0 d=0", out_valid, fifo_out);
        end
        total++;
        if (primed !== 1'b0) begin
            bad++;
            $display("FAIL reset_primed3: got %b want 0", primed);
        end
        mode = 2'd1;
        #1;
        total++;
        if (primed !== 1'b0) begin
            bad++;
            $display("FAIL reset_primed1: got %b want 0", primed);
        end
        mode = 2'd0;
        #1;
        total++;
        if (primed !== 1'b1 || out_valid !== 1'b1 || fifo_out !== 64'hDEAD_BEEF_0123_4567) begin
            bad++;
            $display("FAIL reset_lane0: got p=%b v=%b d=%h want p=1 v=1 d=deadbeef01234567",
                     primed, out_valid, fifo_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_fill();
        do_reset();
        en       = 1'b1;
        mode     = 2'd2;
        in_valid = 4'b0100;
        for (int n = 0; n < 24; n++) begin
            if (n < 14) begin
                set_lane(2, 64'h10 + 64'(n));
                exp_q.push_back('{data: 64'h10 + 64'(n), due: edges + 8});
            end else begin
                in_valid = '0;
                set_lane(2, 64'h0);
            end
            tick();
            total++;
            if (primed !== (edges >= 8)) begin
                bad++;
                $display("FAIL fill_primed edge %0d: got %b want %b", edges, primed, edges >= 8);
            end
            if (exp_q.size() > 0 && exp_q[0].due == edges) begin
                total++;
                if (out_valid !== 1'b1 || fifo_out !== exp_q[0].data) begin
                    bad++;
                    $display("FAIL fill_word edge %0d: got v=%b d=%h want v=1 d=%h",
                             edges, out_valid, fifo_out, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_idle edge %0d: got v=%b want 0", edges, out_valid);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL fill_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_latency_sweep();
        int seen;
        for (int m = 0; m < 4; m++) begin
            do_reset();
            en   = 1'b1;
            mode = 2'(m);
            set_lane(m, 64'hA5A5);
            in_valid = 4'(1 << m);
            if (m == 0) begin
                #1;
                total++;
                if (out_valid !== 1'b1 || fifo_out !== 64'hA5A5) begin
                    bad++;
                    $display("FAIL lat0_pulse: got v=%b d=%h want v=1 d=a5a5", out_valid, fifo_out);
                end
                in_valid = '0;
                set_lane(0, 64'h0);
                #1;
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL lat0_after: got v=%b want 0", out_valid);
                end
            end else begin
                seen = 0;
                exp_q.push_back('{data: 64'hA5A5, due: edges + m * 4});
                for (int i = 0; i < 16; i++) begin
                    tick();
                    if (i == 0) begin
                        in_valid = '0;
                        set_lane(m, 64'h0);
                    end
                    if (exp_q.size() > 0 && exp_q[0].due == edges) begin
                        total++;
                        if (out_valid !== 1'b1 || fifo_out !== 64'hA5A5) begin
                            bad++;
                            $display("FAIL lat%0d_word edge %0d: got v=%b d=%h want v=1 d=a5a5",
                                     m, edges, out_valid, fifo_out);
                        end
                        void'(exp_q.pop_front());
                        seen++;
                    end else begin
                        total++;
                        if (out_valid !== 1'b0) begin
                            bad++;
                            $display("FAIL lat%0d_idle edge %0d: got v=%b want 0", m, edges, out_valid);
                        end
                    end
                end
                total++;
                if (seen != 1) begin
                    bad++;
                    $display("FAIL lat%0d_count: got %0d want 1", m, seen);
                end
            end
        end
    endtask

    task automatic test_stall();
        int          n;
        int          popped;
        logic        en_was;
        logic        last_v;
        logic [63:0] last_d;
        do_reset();
        mode   = 2'd3;
        n      = 0;
        popped = 0;
        last_v = 1'b0;
        last_d = '0;
        for (int c = 0; c < 45; c++) begin
            if (c >= 16 && c < 21) begin
                en       = 1'b0;
                in_valid = 4'($urandom_range(0, 15));
                set_lane(3, 64'($urandom()));
            end else begin
                en = 1'b1;
                if (n < 20) begin
                    in_valid = 4'b1000;
                    set_lane(3, 64'h100 + 64'(n));
                    exp_q.push_back('{data: 64'h100 + 64'(n), due: edges + 12});
                    n++;
                end else begin
                    in_valid = '0;
                    set_lane(3, 64'h0);
                end
            end
            en_was = en;
            tick();
            if (!en_was) begin
                total++;
                if (out_valid !== last_v || (last_v && fifo_out !== last_d)) begin
                    bad++;
                    $display("FAIL stall_hold cyc %0d: got v=%b d=%h want v=%b d=%h",
                             c, out_valid, fifo_out, last_v, last_d);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due == edges) begin
                total++;
                if (out_valid !== 1'b1 || fifo_out !== exp_q[0].data) begin
                    bad++;
                    $display("FAIL stall_word edge %0d: got v=%b d=%h want v=1 d=%h",
                             edges, out_valid, fifo_out, exp_q[0].data);
                end
                last_v = 1'b1;
                last_d = exp_q[0].data;
                void'(exp_q.pop_front());
                popped++;
            end else begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_idle edge %0d: got v=%b want 0", edges, out_valid);
                end
                last_v = 1'b0;
            end
        end
        total++;
        if (popped != 20 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_count: got %0d words want 20", popped);
        end
    endtask

    task automatic test_mode_switch();
        logic [63:0] want;
        do_reset();
        en       = 1'b1;
        mode     = 2'd3;
        in_valid = 4'hF;
        for (int s = 0; s < 18; s++) begin
            for (int k = 0; k < 4; k++) set_lane(k, 64'h1000 * 64'(k) + 64'(s));
            tick();
            if (s == 15 || s == 17) begin
                // Lane k shows the word driven 4k enabled edges ago; lane 0 shows the live input.
                for (int k = 0; k < 4; k++) set_lane(k, 64'h1000 * 64'(k) + 64'(edges));
                for (int mm = 3; mm >= 0; mm--) begin
                    mode = 2'(mm);
                    #1;
                    want = 64'h1000 * 64'(mm) + 64'(edges - 4 * mm);
                    total++;
                    if (out_valid !== 1'b1 || fifo_out !== want) begin
                        bad++;
                        $display("FAIL switch_mode%0d edge %0d: got v=%b d=%h want v=1 d=%h",
                                 mm, edges, out_valid, fifo_out, want);
                    end
                end
                mode = 2'd1;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en       = 1'b1;
        mode     = 2'd3;
        in_valid = 4'b1010;
        for (int s = 0; s < 20; s++) begin
            set_lane(1, 64'h500 + 64'(s));
            set_lane(3, 64'h700 + 64'(s));
            tick();
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = '0;
        total++;
        if (out_valid !== 1'b0 || primed !== 1'b0) begin
            bad++;
            $display("FAIL midrst_after: got v=%b p=%b want v=0 p=0", out_valid, primed);
        end
        for (int i = 0; i < 36; i++) begin
            tick();
            mode = (i % 3 == 1) ? 2'd1 : 2'd3;
            #1;
            total++;
            if (primed !== (edges >= ((mode == 2'd1) ? 4 : 12))) begin
                bad++;
                $display("FAIL midrst_primed mode %0d edge %0d: got %b", mode, edges, primed);
            end
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL midrst_flushed edge %0d: got v=%b want 0", edges, out_valid);
            end
        end
    endtask

    task automatic test_zero_invalid();
        logic [3:0]  pat;
        logic        want_v;
        logic [63:0] want_d;
        pat = 4'b0101;  // bit j is the valid for the j-th driven word
        do_reset();
        en   = 1'b1;
        mode = 2'd1;
        set_lane(1, 64'hFF);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 4) ? {2'b00, pat[i], 1'b0} : 4'b0000;
            if (i < 4 && pat[i]) exp_q.push_back('{data: 64'hFF, due: edges + 4});
            tick();
            want_v = (exp_q.size() > 0 && exp_q[0].due == edges);
            if (want_v) void'(exp_q.pop_front());
`ifdef HFIFO_ZERO_INVALID_EN
            want_d = want_v ? 64'hFF : 64'h0;
`else
            want_d = (edges >= 4) ? 64'hFF : 64'h0;
`endif
            total++;
            if (out_valid !== want_v || fifo_out !== want_d) begin
                bad++;
                $display("FAIL bubble edge %0d: got v=%b d=%h want v=%b d=%h",
                         edges, out_valid, fifo_out, want_v, want_d);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        in_valid = '0;
        data_in  = '0;
        mode     = '0;
        test_reset();
        test_reset_fill();
        test_latency_sweep();
        test_stall();
        test_mode_switch();
        test_reset_mid();
        test_zero_invalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
